// File: rtl/seq_alu_pkg.sv
// Shared definitions for the sequential ALU: opcode encodings, FSM states,
// and the shift-amount width helper.
package alu_pkg;

  localparam logic [4:0] ALU_AND  = 5'b00000;
  localparam logic [4:0] ALU_MFLO = 5'b00001;
  localparam logic [4:0] ALU_OR   = 5'b00010;
  localparam logic [4:0] ALU_LUI  = 5'b00011;
  localparam logic [4:0] ALU_ADD  = 5'b00100;
  localparam logic [4:0] ALU_XOR  = 5'b00110;
  localparam logic [4:0] ALU_MULT = 5'b01000;
  localparam logic [4:0] ALU_DIV  = 5'b01010;
  localparam logic [4:0] ALU_SUB  = 5'b01100;
  localparam logic [4:0] ALU_SLT  = 5'b01110;
  localparam logic [4:0] ALU_SLL  = 5'b10000;
  localparam logic [4:0] ALU_SRL  = 5'b10010;
  localparam logic [4:0] ALU_SRA  = 5'b10100;
  localparam logic [4:0] ALU_SLLV = 5'b10110;
  localparam logic [4:0] ALU_NOR  = 5'b11000;
  localparam logic [4:0] ALU_SRLV = 5'b11001;
  localparam logic [4:0] ALU_BNE  = 5'b11010;
  localparam logic [4:0] ALU_BLEZ = 5'b11100;
  localparam logic [4:0] ALU_BGTZ = 5'b11110;
  localparam logic [4:0] ALU_MFHI = 5'b11111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2
  } state_t;

  function automatic int unsigned shamt_width(input int unsigned width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/seq_alu_if.sv
// Operand/result handshake bundle between the control unit and seq_alu.
interface seq_alu_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned OPW   = 5
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] opA;
  logic [WIDTH-1:0] opB;
  logic [OPW-1:0]   ALUop;
  logic             out_valid;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             div_by_zero;
  logic             illegal_op;

  modport master (
    output in_valid, opA, opB, ALUop,
    input  in_ready, out_valid, result, zero, div_by_zero, illegal_op
  );

  modport slave (
    input  in_valid, opA, opB, ALUop,
    output in_ready, out_valid, result, zero, div_by_zero, illegal_op
  );
endinterface

// File: rtl/seq_alu_muldiv.sv
// Iterative unsigned shift-add multiplier / restoring divider, one bit per cycle.
// o_hi/o_lo present the value of the final iteration while o_done is high.
module seq_alu_muldiv
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_start,
  input  logic             i_op_is_div,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo,
  output logic             o_dz
);
  localparam int unsigned CW = shamt_width(WIDTH);

  logic             r_busy;
  logic             r_is_div;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic             r_dz;

  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_shift;
  logic             w_lt;
  logic [WIDTH-1:0] w_sub;
  logic [WIDTH-1:0] w_hi_nxt;
  logic [WIDTH-1:0] w_lo_nxt;

  // Divide by zero needs no special case: every trial subtract succeeds,
  // so the quotient fills with ones and the dividend shifts into the remainder.
  always_comb begin
    w_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_a} : '0);
    w_shift = {r_hi, r_lo[WIDTH-1]};
    w_lt    = w_shift < {1'b0, r_a};
    w_sub   = w_shift[WIDTH-1:0] - r_a;
    if (r_is_div) begin
      w_hi_nxt = w_lt ? w_shift[WIDTH-1:0] : w_sub;
      w_lo_nxt = {r_lo[WIDTH-2:0], ~w_lt};
    end else begin
      w_hi_nxt = w_sum[WIDTH:1];
      w_lo_nxt = {w_sum[0], r_lo[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy   <= 1'b0;
      r_is_div <= 1'b0;
      r_cnt    <= '0;
      r_a      <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_dz     <= 1'b0;
    end else if (i_start && !r_busy) begin
      r_busy   <= 1'b1;
      r_is_div <= i_op_is_div;
      r_cnt    <= '0;
      r_a      <= i_op_is_div ? i_b : i_a;
      r_hi     <= '0;
      r_lo     <= i_op_is_div ? i_a : i_b;
      r_dz     <= i_op_is_div && (i_b == '0);
    end else if (r_busy) begin
      r_hi  <= w_hi_nxt;
      r_lo  <= w_lo_nxt;
      r_cnt <= r_cnt + CW'(1);
      if (o_done) begin
        r_busy <= 1'b0;
        r_cnt  <= '0;
      end
    end
  end

  assign o_busy = r_busy;
  assign o_done = r_busy && (r_cnt == CW'(WIDTH - 1));
  assign o_hi   = w_hi_nxt;
  assign o_lo   = w_lo_nxt;
  assign o_dz   = r_dz;

endmodule

// File: rtl/seq_alu.sv
// Registered execute-stage ALU: single-cycle ops complete the cycle after
// acceptance; mult/div run in seq_alu_muldiv and update HI/LO on completion.
module seq_alu
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned OPW   = 5
) (
  input  logic       clk,
  input  logic       reset,
  seq_alu_if.slave   bus
);
  localparam int unsigned SHW = shamt_width(WIDTH);

  state_t           r_state;
  logic [WIDTH-1:0] r_result;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic             r_zero;
  logic             r_out_valid;
  logic             r_dz;
  logic             r_illegal;

  logic [4:0]       w_op;
  logic             w_op_hi_ok;
  logic             w_is_mul;
  logic             w_is_div;
  logic             w_accept;
  logic             w_start;
  logic [WIDTH-1:0] w_diff;
  logic [WIDTH-1:0] w_res;
  logic             w_illegal;
  logic             w_busy;
  logic             w_done;
  logic             w_dz;
  logic [WIDTH-1:0] w_md_hi;
  logic [WIDTH-1:0] w_md_lo;

  // Opcode bits above the 5-bit encoding must be zero for a legal op.
  assign w_op       = bus.ALUop[4:0];
  assign w_op_hi_ok = ((bus.ALUop >> 5) == '0);
  assign w_is_mul   = w_op_hi_ok && (w_op == ALU_MULT);
  assign w_is_div   = w_op_hi_ok && (w_op == ALU_DIV);
  assign w_accept   = bus.in_valid && bus.in_ready;
  assign w_start    = w_accept && (w_is_mul || w_is_div);
  assign w_diff     = bus.opA - bus.opB;

  always_comb begin
    w_res     = '0;
    w_illegal = 1'b0;
    if (!w_op_hi_ok) begin
      w_illegal = 1'b1;
    end else begin
      case (w_op)
        ALU_AND:  w_res = bus.opA & bus.opB;
        ALU_OR:   w_res = bus.opA | bus.opB;
        ALU_XOR:  w_res = bus.opA ^ bus.opB;
        ALU_NOR:  w_res = ~(bus.opA | bus.opB);
        ALU_ADD:  w_res = bus.opA + bus.opB;
        ALU_SUB:  w_res = w_diff;
        ALU_SLL:  w_res = bus.opA << 1;
        ALU_SRL:  w_res = bus.opA >> 1;
        ALU_SRA:  w_res = {bus.opA[WIDTH-1], bus.opA[WIDTH-1:1]};
        ALU_SLLV: w_res = bus.opA << bus.opB[SHW-1:0];
        ALU_SRLV: w_res = bus.opA >> bus.opB[SHW-1:0];
        ALU_BNE:  w_res = ~w_diff;
        ALU_BLEZ: w_res = {{(WIDTH-1){1'b0}}, w_diff[WIDTH-1] | ~|w_diff};
        ALU_BGTZ: w_res = {{(WIDTH-1){1'b0}}, ~(w_diff[WIDTH-1] | ~|w_diff)};
        ALU_LUI:  w_res = bus.opA << (WIDTH / 2);
        ALU_SLT:  w_res = {{(WIDTH-1){1'b0}}, $signed(bus.opA) < $signed(bus.opB)};
        ALU_MFHI: w_res = r_hi;
        ALU_MFLO: w_res = r_lo;
        ALU_MULT, ALU_DIV: w_res = '0;
        default:  w_illegal = 1'b1;
      endcase
    end
  end

  seq_alu_muldiv #(
    .WIDTH(WIDTH)
  ) u_muldiv (
    .clk        (clk),
    .rst        (reset),
    .i_start    (w_start),
    .i_op_is_div(w_is_div),
    .i_a        (bus.opA),
    .i_b        (bus.opB),
    .o_busy     (w_busy),
    .o_done     (w_done),
    .o_hi       (w_md_hi),
    .o_lo       (w_md_lo),
    .o_dz       (w_dz)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_result    <= '0;
      r_zero      <= 1'b1;
      r_out_valid <= 1'b0;
      r_dz        <= 1'b0;
      r_illegal   <= 1'b0;
      r_hi        <= '0;
      r_lo        <= '0;
    end else begin
      r_out_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            if (w_is_mul) begin
              r_state <= MUL;
            end else if (w_is_div) begin
              r_state <= DIV;
            end else begin
              r_result    <= w_res;
              r_zero      <= (w_res == '0);
              r_illegal   <= w_illegal;
              r_dz        <= 1'b0;
              r_out_valid <= 1'b1;
            end
          end
        end
        MUL, DIV: begin
          if (w_done) begin
            r_hi        <= w_md_hi;
            r_lo        <= w_md_lo;
            r_result    <= w_md_lo;
            r_zero      <= (w_md_lo == '0);
            r_illegal   <= 1'b0;
            r_dz        <= w_dz;
            r_out_valid <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready    = (r_state == IDLE) && !w_busy;
  assign bus.out_valid   = r_out_valid;
  assign bus.result      = r_result;
  assign bus.zero        = r_zero;
  assign bus.div_by_zero = r_dz;
  assign bus.illegal_op  = r_illegal;

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu (WIDTH=32): directed cases plus random ops
// checked against a plain-arithmetic reference model with its own HI/LO state.
module tb_seq_alu;

  localparam int W = 32;

  localparam logic [4:0] OP_AND  = 5'b00000;
  localparam logic [4:0] OP_MFLO = 5'b00001;
  localparam logic [4:0] OP_OR   = 5'b00010;
  localparam logic [4:0] OP_LUI  = 5'b00011;
  localparam logic [4:0] OP_ADD  = 5'b00100;
  localparam logic [4:0] OP_XOR  = 5'b00110;
  localparam logic [4:0] OP_MULT = 5'b01000;
  localparam logic [4:0] OP_DIV  = 5'b01010;
  localparam logic [4:0] OP_SUB  = 5'b01100;
  localparam logic [4:0] OP_SLT  = 5'b01110;
  localparam logic [4:0] OP_SLL  = 5'b10000;
  localparam logic [4:0] OP_SRL  = 5'b10010;
  localparam logic [4:0] OP_SRA  = 5'b10100;
  localparam logic [4:0] OP_SLLV = 5'b10110;
  localparam logic [4:0] OP_NOR  = 5'b11000;
  localparam logic [4:0] OP_SRLV = 5'b11001;
  localparam logic [4:0] OP_BNE  = 5'b11010;
  localparam logic [4:0] OP_BLEZ = 5'b11100;
  localparam logic [4:0] OP_BGTZ = 5'b11110;
  localparam logic [4:0] OP_MFHI = 5'b11111;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  seq_alu_if #(.WIDTH(W), .OPW(5)) bus ();
  seq_alu #(.WIDTH(W), .OPW(5)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int n_err = 0;
  int n_chk = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;
  logic [4:0] legal [20] = '{OP_AND, OP_MFLO, OP_OR, OP_LUI, OP_ADD, OP_XOR, OP_MULT,
                             OP_DIV, OP_SUB, OP_SLT, OP_SLL, OP_SRL, OP_SRA, OP_SLLV,
                             OP_NOR, OP_SRLV, OP_BNE, OP_BLEZ, OP_BGTZ, OP_MFHI};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic bit is_legal(input logic [4:0] op);
    for (int i = 0; i < 20; i++) if (legal[i] == op) return 1'b1;
    return 1'b0;
  endfunction

  // Reference model: result/flags/latency and the HI/LO the op leaves behind.
  function automatic void model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] r, output logic ill, output logic dz,
                                output logic [31:0] nhi, output logic [31:0] nlo, output int lat);
    logic [63:0] p;
    logic [31:0] d;
    d = a - b;
    nhi = m_hi; nlo = m_lo; ill = 1'b0; dz = 1'b0; lat = 1; r = '0;
    case (op)
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      OP_NOR:  r = ~(a | b);
      OP_ADD:  r = a + b;
      OP_SUB:  r = d;
      OP_SLL:  r = a << 1;
      OP_SRL:  r = a >> 1;
      OP_SRA:  r = $signed(a) >>> 1;
      OP_SLLV: r = a << b[4:0];
      OP_SRLV: r = a >> b[4:0];
      OP_BNE:  r = ~d;
      OP_BLEZ: r = ($signed(d) <= 0) ? 32'd1 : 32'd0;
      OP_BGTZ: r = ($signed(d) > 0) ? 32'd1 : 32'd0;
      OP_LUI:  r = a * 32'h10000;
      OP_SLT:  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      OP_MFHI: r = m_hi;
      OP_MFLO: r = m_lo;
      OP_MULT: begin
        p = 64'(a) * 64'(b);
        nhi = p[63:32]; nlo = p[31:0]; r = nlo; lat = W + 1;
      end
      OP_DIV: begin
        lat = W + 1;
        if (b == 0) begin dz = 1'b1; nlo = '1; nhi = a; end
        else begin nlo = a / b; nhi = a % b; end
        r = nlo;
      end
      default: ill = 1'b1;
    endcase
  endfunction

  // Issue one op at the next edge, then wait (bounded) for its out_valid.
  task automatic do_op(input string tag, input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] er, nhi, nlo;
    logic eill, edz;
    int elat, lat, busy;
    model(op, a, b, er, eill, edz, nhi, nlo, elat);
    chk({tag, ".in_ready"}, bus.in_ready, 1);
    bus.in_valid = 1'b1; bus.ALUop = op; bus.opA = a; bus.opB = b;
    @(posedge clk); #1;
    bus.in_valid = 1'b0; bus.opA = $urandom; bus.opB = $urandom; bus.ALUop = 5'($urandom);
    lat = 1; busy = 0;
    while (!bus.out_valid && lat < 100) begin
      if (!bus.in_ready) busy++;
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, ".latency"}, lat, elat);
    chk({tag, ".busy_cycles"}, busy, elat - 1);
    chk({tag, ".result"}, bus.result, er);
    chk({tag, ".zero"}, bus.zero, (er == 0));
    chk({tag, ".illegal_op"}, bus.illegal_op, eill);
    chk({tag, ".div_by_zero"}, bus.div_by_zero, edz);
    m_hi = nhi; m_lo = nlo;
  endtask

  initial begin
    logic [4:0] rop;
    int lat, pulses;
    reset = 1'b1;
    bus.in_valid = 1'b0; bus.opA = '0; bus.opB = '0; bus.ALUop = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.out_valid", bus.out_valid, 0);
    chk("rst.result", bus.result, 0);
    chk("rst.zero", bus.zero, 1);
    chk("rst.in_ready", bus.in_ready, 1);
    chk("rst.flags", {bus.div_by_zero, bus.illegal_op}, 0);
    reset = 1'b0;
    @(posedge clk); #1;

    do_op("add_wrap", OP_ADD, 32'hFFFF_FFFF, 32'd1);
    do_op("sub_neg", OP_SUB, 32'd5, 32'd7);
    do_op("mult", OP_MULT, 32'h0001_0000, 32'h0003_0000);
    do_op("mfhi_mult", OP_MFHI, 32'd0, 32'd0);
    do_op("mflo_mult", OP_MFLO, 32'd0, 32'd0);
    do_op("div", OP_DIV, 32'd100, 32'd7);
    do_op("mfhi_div", OP_MFHI, 32'd0, 32'd0);
    do_op("div_zero", OP_DIV, 32'h1234, 32'd0);
    do_op("mfhi_dz", OP_MFHI, 32'd0, 32'd0);
    do_op("sra", OP_SRA, 32'h8000_0000, 32'd0);
    do_op("slt", OP_SLT, 32'hFFFF_FFFF, 32'd1);
    do_op("lui", OP_LUI, 32'h1234, 32'd0);
    do_op("illegal", 5'b00101, 32'hDEAD_BEEF, 32'h1);
    do_op("blez_eq", OP_BLEZ, 32'd9, 32'd9);
    do_op("bgtz_pos", OP_BGTZ, 32'd10, 32'd9);

    // add held on in_valid during a mult: accepted only once in_ready returns
    bus.in_valid = 1'b1; bus.ALUop = OP_MULT; bus.opA = 32'd6; bus.opB = 32'd7;
    @(posedge clk); #1;
    bus.ALUop = OP_ADD; bus.opA = 32'd3; bus.opB = 32'd4;
    lat = 1;
    while (!bus.out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
    chk("held.mult_latency", lat, W + 1);
    chk("held.mult_result", bus.result, 42);
    m_hi = '0; m_lo = 32'd42;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    chk("held.add_valid", bus.out_valid, 1);
    chk("held.add_result", bus.result, 7);
    @(posedge clk); #1;
    chk("held.pulse_end", bus.out_valid, 0);
    do_op("mflo_held", OP_MFLO, 32'd0, 32'd0);

    // reset in the middle of a mult
    bus.in_valid = 1'b1; bus.ALUop = OP_MULT; bus.opA = 32'hFFFF; bus.opB = 32'h1234;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    #2 reset = 1'b1;
    #1;
    chk("midrst.out_valid", bus.out_valid, 0);
    chk("midrst.in_ready", bus.in_ready, 1);
    chk("midrst.result", bus.result, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    m_hi = '0; m_lo = '0;
    pulses = 0;
    repeat (40) begin @(posedge clk); #1; if (bus.out_valid) pulses++; end
    chk("midrst.no_out_valid", pulses, 0);
    do_op("midrst.mfhi", OP_MFHI, 32'd0, 32'd0);
    do_op("midrst.mflo", OP_MFLO, 32'd0, 32'd0);

    for (int k = 0; k < 60; k++) begin
      if ($urandom_range(0, 9) == 0) begin
        rop = 5'($urandom_range(0, 31));
        for (int t = 0; t < 64 && is_legal(rop); t++) rop = 5'($urandom_range(0, 31));
      end else begin
        rop = legal[$urandom_range(0, 19)];
      end
      do_op($sformatf("rand%0d_op%05b", k, rop), rop, $urandom,
            ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
